// File: rtl/map_scroller.sv
// Horizontal-scroll address stage: maps DTG pixel coordinates to world/tile coordinates,
// drives the map BRAM address and delays coordinates to line up with the BRAM read data.
module map_scroller #(
    parameter int unsigned SCREEN_W   = 640,
    parameter int unsigned SCREEN_H   = 480,
    parameter int unsigned TILE_LOG2  = 3,
    parameter int unsigned MAP_W_LOG2 = 8,
    parameter int unsigned MAP_H_LOG2 = 6,
    parameter int unsigned MAX_OFFSET = 1408
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [11:0]                      pixel_row,
    input  logic [11:0]                      pixel_column,
    input  logic                             frame_tick,
    input  logic                             scroll_en,
    input  logic                             scroll_dir,
    input  logic [3:0]                       scroll_step,
    output logic [MAP_H_LOG2+MAP_W_LOG2-1:0] map_addr,
    output logic [11:0]                      pixel_row_out,
    output logic [11:0]                      world_col_out,
    output logic                             out_of_map,
    output logic [MAP_W_LOG2+TILE_LOG2-1:0]  scroll_offset,
    output logic                             at_left_edge,
    output logic                             at_right_edge
);

    localparam int unsigned ADDR_W = MAP_H_LOG2 + MAP_W_LOG2;
    localparam int unsigned OFF_W  = MAP_W_LOG2 + TILE_LOG2;
    localparam int unsigned CRD_W  = 12;

    localparam logic [CRD_W-1:0] SCREEN_W_C = CRD_W'(SCREEN_W);
    localparam logic [CRD_W-1:0] SCREEN_H_C = CRD_W'(SCREEN_H);
    localparam logic [CRD_W-1:0] MAP_PX_H   = CRD_W'(1 << (MAP_H_LOG2 + TILE_LOG2));
    localparam logic [CRD_W-1:0] MAP_PX_W   = CRD_W'(1 << (MAP_W_LOG2 + TILE_LOG2));
    localparam logic [CRD_W-1:0] MAX_OFF_C  = CRD_W'(MAX_OFFSET);

    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [ADDR_W-1:0] map_addr_q, map_addr_d;
    logic [CRD_W-1:0]  row1_q, wc1_q, row2_q, wc2_q;
    logic              oob1_q, oob2_q;
    logic [CRD_W-1:0]  wc_d;
    logic              oob_d;

    // Saturating scroll update, evaluated in 12 bits so the right-hand sum never wraps.
    logic [CRD_W-1:0] off_ext, step_ext, sum_ext;
    always_comb begin
        offset_d = offset_q;
        off_ext  = CRD_W'(offset_q);
        step_ext = CRD_W'(scroll_step);
        sum_ext  = off_ext + step_ext;
        if (frame_tick && scroll_en) begin
            if (!scroll_dir) begin
                offset_d = (sum_ext > MAX_OFF_C) ? OFF_W'(MAX_OFF_C) : OFF_W'(sum_ext);
            end else begin
                offset_d = (off_ext < step_ext) ? '0 : OFF_W'(off_ext - step_ext);
            end
        end
    end

    // Stage 1: world column, out-of-map decision and tile address.
    always_comb begin
        wc_d  = pixel_column + CRD_W'(offset_q);
        oob_d = (pixel_column >= SCREEN_W_C) | (pixel_row >= SCREEN_H_C) |
                (pixel_row >= MAP_PX_H) | (wc_d >= MAP_PX_W);
        map_addr_d = oob_d ? '0 :
                     {pixel_row[TILE_LOG2 +: MAP_H_LOG2], wc_d[TILE_LOG2 +: MAP_W_LOG2]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            offset_q   <= '0;
            map_addr_q <= '0;
            row1_q     <= '0;
            wc1_q      <= '0;
            oob1_q     <= 1'b1;
            row2_q     <= '0;
            wc2_q      <= '0;
            oob2_q     <= 1'b1;
        end else begin
            offset_q   <= offset_d;
            map_addr_q <= map_addr_d;
            row1_q     <= pixel_row;
            wc1_q      <= wc_d;
            oob1_q     <= oob_d;
            row2_q     <= row1_q;
            wc2_q      <= wc1_q;
            oob2_q     <= oob1_q;
        end
    end

    assign map_addr      = map_addr_q;
    assign pixel_row_out = row2_q;
    assign world_col_out = wc2_q;
    assign out_of_map    = oob2_q;
    assign scroll_offset = offset_q;
    assign at_left_edge  = (offset_q == '0);
    assign at_right_edge = (offset_q == OFF_W'(MAX_OFFSET));

endmodule

// File: tb/tb_map_scroller.sv
// Directed self-checking bench for map_scroller: reset, latency, saturation, boundaries, ticks.
module tb_map_scroller;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] pixel_row, pixel_column;
    logic        frame_tick, scroll_en, scroll_dir;
    logic [3:0]  scroll_step;
    logic [13:0] map_addr;
    logic [11:0] pixel_row_out, world_col_out;
    logic        out_of_map;
    logic [10:0] scroll_offset;
    logic        at_left_edge, at_right_edge;

    int n_cmp = 0;
    int n_fail = 0;

    map_scroller dut (
        .clk(clk), .reset(reset), .pixel_row(pixel_row), .pixel_column(pixel_column),
        .frame_tick(frame_tick), .scroll_en(scroll_en), .scroll_dir(scroll_dir),
        .scroll_step(scroll_step), .map_addr(map_addr), .pixel_row_out(pixel_row_out),
        .world_col_out(world_col_out), .out_of_map(out_of_map),
        .scroll_offset(scroll_offset), .at_left_edge(at_left_edge),
        .at_right_edge(at_right_edge)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic dir, input logic [3:0] st, input int n);
        for (int i = 0; i < n; i++) begin
            scroll_en = 1'b1; scroll_dir = dir; scroll_step = st; frame_tick = 1'b1;
            step();
        end
        frame_tick = 1'b0; scroll_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pixel_row = 12'd17; pixel_column = 12'd42; frame_tick = 1'b1; scroll_en = 1'b1;
        scroll_dir = 1'b0; scroll_step = 4'd9; reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        frame_tick = 1'b0; scroll_en = 1'b0;
        n_cmp++; if (scroll_offset !== 11'd0) begin n_fail++; $display("FAIL reset_offset got %0d want 0", scroll_offset); end
        n_cmp++; if (out_of_map !== 1'b1) begin n_fail++; $display("FAIL reset_oob got %b want 1", out_of_map); end
        n_cmp++; if (map_addr !== 14'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", map_addr); end
        n_cmp++; if (at_left_edge !== 1'b1) begin n_fail++; $display("FAIL reset_left got %b want 1", at_left_edge); end
        n_cmp++; if (at_right_edge !== 1'b0) begin n_fail++; $display("FAIL reset_right got %b want 0", at_right_edge); end
        n_cmp++; if (world_col_out !== 12'd0 || pixel_row_out !== 12'd0) begin n_fail++; $display("FAIL reset_coords got %0d/%0d want 0/0", pixel_row_out, world_col_out); end
        reset = 1'b0;
    endtask

    task automatic test_latency();
        pixel_row = 12'd17; pixel_column = 12'd42;
        step();
        pixel_column = 12'd700;
        n_cmp++; if (map_addr !== 14'h0205) begin n_fail++; $display("FAIL lat_addr got %h want 0205", map_addr); end
        n_cmp++; if (out_of_map !== 1'b1) begin n_fail++; $display("FAIL lat_early_oob got %b want 1", out_of_map); end
        step();
        n_cmp++; if (pixel_row_out !== 12'd17) begin n_fail++; $display("FAIL lat_row got %0d want 17", pixel_row_out); end
        n_cmp++; if (world_col_out !== 12'd42) begin n_fail++; $display("FAIL lat_wc got %0d want 42", world_col_out); end
        n_cmp++; if (out_of_map !== 1'b0) begin n_fail++; $display("FAIL lat_oob got %b want 0", out_of_map); end
        n_cmp++; if (map_addr !== 14'd0) begin n_fail++; $display("FAIL lat_addr_oob got %h want 0", map_addr); end
        step();
        n_cmp++; if (out_of_map !== 1'b1) begin n_fail++; $display("FAIL lat_oob2 got %b want 1", out_of_map); end
    endtask

    task automatic test_right_sat();
        do_reset();
        tick(1'b0, 4'd14, 100);
        n_cmp++; if (scroll_offset !== 11'd1400) begin n_fail++; $display("FAIL rsat_start got %0d want 1400", scroll_offset); end
        tick(1'b0, 4'd15, 1);
        n_cmp++; if (scroll_offset !== 11'd1408) begin n_fail++; $display("FAIL rsat_1 got %0d want 1408", scroll_offset); end
        n_cmp++; if (at_right_edge !== 1'b1) begin n_fail++; $display("FAIL rsat_edge got %b want 1", at_right_edge); end
        tick(1'b0, 4'd15, 1);
        n_cmp++; if (scroll_offset !== 11'd1408) begin n_fail++; $display("FAIL rsat_2 got %0d want 1408", scroll_offset); end
        pixel_row = 12'd0; pixel_column = 12'd639;
        step();
        n_cmp++; if (map_addr[7:0] !== 8'd255) begin n_fail++; $display("FAIL rsat_addr got %0d want 255", map_addr[7:0]); end
        step();
        n_cmp++; if (world_col_out !== 12'd2047) begin n_fail++; $display("FAIL rsat_wc got %0d want 2047", world_col_out); end
        n_cmp++; if (out_of_map !== 1'b0) begin n_fail++; $display("FAIL rsat_oob got %b want 0", out_of_map); end
    endtask

    task automatic test_left_sat();
        tick(1'b1, 4'd15, 93);
        tick(1'b1, 4'd10, 1);
        n_cmp++; if (scroll_offset !== 11'd3) begin n_fail++; $display("FAIL lsat_start got %0d want 3", scroll_offset); end
        n_cmp++; if (at_left_edge !== 1'b0 || at_right_edge !== 1'b0) begin n_fail++; $display("FAIL lsat_mid_edges got %b%b want 00", at_left_edge, at_right_edge); end
        tick(1'b1, 4'd5, 1);
        n_cmp++; if (scroll_offset !== 11'd0) begin n_fail++; $display("FAIL lsat_1 got %0d want 0", scroll_offset); end
        n_cmp++; if (at_left_edge !== 1'b1) begin n_fail++; $display("FAIL lsat_edge got %b want 1", at_left_edge); end
        tick(1'b1, 4'd5, 1);
        n_cmp++; if (scroll_offset !== 11'd0) begin n_fail++; $display("FAIL lsat_2 got %0d want 0", scroll_offset); end
    endtask

    task automatic test_oob();
        logic [11:0] rows [3] = '{12'd10, 12'd480, 12'd479};
        logic [11:0] cols [3] = '{12'd640, 12'd0, 12'd639};
        logic [13:0] exp_a [3] = '{14'd0, 14'd0, 14'h3B4F};
        logic        exp_o [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            pixel_row = rows[i]; pixel_column = cols[i];
            step();
            n_cmp++; if (map_addr !== exp_a[i]) begin n_fail++; $display("FAIL oob_addr[%0d] got %h want %h", i, map_addr, exp_a[i]); end
            step();
            n_cmp++; if (out_of_map !== exp_o[i]) begin n_fail++; $display("FAIL oob_flag[%0d] got %b want %b", i, out_of_map, exp_o[i]); end
        end
    endtask

    task automatic test_tick_interactions();
        tick(1'b0, 4'd7, 1);
        n_cmp++; if (scroll_offset !== 11'd7) begin n_fail++; $display("FAIL tick_base got %0d want 7", scroll_offset); end
        scroll_en = 1'b0; scroll_step = 4'd7; frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        n_cmp++; if (scroll_offset !== 11'd7) begin n_fail++; $display("FAIL tick_no_en got %0d want 7", scroll_offset); end
        scroll_en = 1'b1; scroll_step = 4'd7;
        step();
        scroll_en = 1'b0;
        n_cmp++; if (scroll_offset !== 11'd7) begin n_fail++; $display("FAIL tick_no_tick got %0d want 7", scroll_offset); end
        tick(1'b0, 4'd0, 1);
        n_cmp++; if (scroll_offset !== 11'd7) begin n_fail++; $display("FAIL tick_step0 got %0d want 7", scroll_offset); end
        do_reset();
        tick(1'b0, 4'd14, 50);
        n_cmp++; if (scroll_offset !== 11'd700) begin n_fail++; $display("FAIL tick_700 got %0d want 700", scroll_offset); end
        reset = 1'b1; scroll_en = 1'b1; scroll_dir = 1'b0; scroll_step = 4'd15; frame_tick = 1'b1;
        step();
        reset = 1'b0; scroll_en = 1'b0; frame_tick = 1'b0;
        n_cmp++; if (scroll_offset !== 11'd0) begin n_fail++; $display("FAIL tick_reset_wins got %0d want 0", scroll_offset); end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 4'd7, 1);
        pixel_row = 12'd100;
        for (int i = 0; i < 8; i++) begin
            pixel_column = 12'(i * 8);
            step();
            if (i >= 1) begin
                n_cmp++; if (world_col_out !== 12'((i - 1) * 8 + 7)) begin n_fail++; $display("FAIL b2b_wc[%0d] got %0d want %0d", i, world_col_out, (i - 1) * 8 + 7); end
            end
        end
    endtask

    task automatic test_midframe_reset();
        pixel_row = 12'd20; pixel_column = 12'd30;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (out_of_map !== 1'b1) begin n_fail++; $display("FAIL mid_rst_0 got %b want 1", out_of_map); end
        step();
        n_cmp++; if (out_of_map !== 1'b1) begin n_fail++; $display("FAIL mid_rst_1 got %b want 1", out_of_map); end
        step();
        n_cmp++; if (out_of_map !== 1'b0) begin n_fail++; $display("FAIL mid_rst_2 got %b want 0", out_of_map); end
        n_cmp++; if (world_col_out !== 12'd30) begin n_fail++; $display("FAIL mid_rst_wc got %0d want 30", world_col_out); end
    endtask

    initial begin
        reset = 1'b1; pixel_row = '0; pixel_column = '0;
        frame_tick = 1'b0; scroll_en = 1'b0; scroll_dir = 1'b0; scroll_step = '0;
        #1;
        test_reset();
        test_latency();
        test_right_sat();
        test_left_sat();
        test_oob();
        test_tick_interactions();
        test_back_to_back();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/map_scroller.md
# map_scroller

Horizontal-scroll address stage that sits directly upstream of the map colorizer and the map memory. It converts display pixel coordinates from the DTG into world coordinates using a per-frame scroll offset, and drives the tile address to the synchronous map BRAM. It delays the pixel coordinates and the out-of-map flag so they arrive at the colorizer in the same cycle as the BRAM's `map_value`. The scroll offset is updated only on a frame tick and saturates at both map edges.

## Interface
- `SCREEN_W`, 640, visible columns
- `SCREEN_H`, 480, visible rows
- `TILE_LOG2`, 3, log2 of tile edge in pixels (8×8 tiles)
- `MAP_W_LOG2`, 8, log2 of map width in tiles (256 tiles = 2048 px)
- `MAP_H_LOG2`, 6, log2 of map height in tiles (64 tiles = 512 px)
- `MAX_OFFSET`, 1408, largest legal scroll offset (2^(MAP_W_LOG2+TILE_LOG2) − SCREEN_W)
- `clk`  in  1  system clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `pixel_row`  in  12  DTG row
- `pixel_column`  in  12  DTG column
- `frame_tick`  in  1  one-cycle pulse, asserted by the DTG during vertical blank
- `scroll_en`  in  1  apply a scroll step on the next `frame_tick`
- `scroll_dir`  in  1  0 = right (offset increases), 1 = left (offset decreases)
- `scroll_step`  in  4  pixels per frame, unsigned
- `map_addr`  out  14  BRAM address `{tile_row[5:0], tile_col[7:0]}`; BRAM read latency is 1 cycle
- `pixel_row_out`  out  12  row, aligned with BRAM `map_value`
- `world_col_out`  out  12  world column (`pixel_column + offset`), aligned with BRAM `map_value`
- `out_of_map`  out  1  aligned with BRAM `map_value`; feeds the colorizer
- `scroll_offset`  out  11  current offset
- `at_left_edge`  out  1  `scroll_offset == 0`
- `at_right_edge`  out  1  `scroll_offset == MAX_OFFSET`

## Operation
- **Offset register.**
  - Reset value is 0. The register changes only in a cycle where `frame_tick` is 1 and `scroll_en` is 1.
  - Right: `offset ← min(offset + step, MAX_OFFSET)`.
  - Left: `offset ← (offset < step) ? 0 : offset − step`.
  - Compute in 12 bits so the sum cannot wrap. `scroll_step == 0` leaves the offset unchanged.
- **Edge flags.** `at_left_edge` and `at_right_edge` are combinational from the offset register.
- **Stage 1 (registered).**
  - `wc = pixel_column + offset`, 12-bit.
  - `oob = (pixel_column >= SCREEN_W) | (pixel_row >= SCREEN_H) | (pixel_row >= 2^(MAP_H_LOG2+TILE_LOG2)) | (wc >= 2^(MAP_W_LOG2+TILE_LOG2))`.
  - `map_addr ← oob ? 0 : {pixel_row[8:3], wc[10:3]}`. Address slicing follows the parameters.
  - `pixel_row` and `wc` are also captured, along with `oob`.
- **Stage 2 (registered).** Stage 1 `pixel_row`, `wc` and `oob` are copied to `pixel_row_out`, `world_col_out` and `out_of_map`.
- **Offset sampling.** The offset used by stage 1 is the offset register value in that cycle. Because `frame_tick` occurs in blank, the offset is constant across every visible line.

## Timing
- **Latency.** Input coordinates at cycle N produce:
  - `map_addr` at N+1;
  - BRAM `map_value` at N+2;
  - `pixel_row_out`, `world_col_out` and `out_of_map` at N+2.
- **Offset update.**
  - `frame_tick` at cycle T → new `scroll_offset` visible at T+1, and used by stage 1 from T+1.
  - Edge flags update at T+1.
- **Reset values.**
  - Offset, `map_addr`, `pixel_row_out` and `world_col_out` are 0.
  - `out_of_map` is 1, in both stage 1 and stage 2.
  - `at_left_edge` is 1 and `at_right_edge` is 0.
- **Reset asserted mid-frame.**
  - The pipeline clears on the next edge.
  - Outputs are out-of-map for 2 cycles after release, until real data propagates.
- **Simultaneous `reset` and `frame_tick`.** Reset wins; the offset is 0.
- **`frame_tick` with `scroll_en` = 0.** No change.
- **`frame_tick` asserted during active video.** This is not a legal DTG behaviour. The block still applies the update; no guard is implemented.
- **Throughput.** The pipeline runs every cycle; there is no stall and no handshake.

## Test plan
- **Reset.** Hold `reset` 3 cycles → `scroll_offset` = 0, `out_of_map` = 1, `map_addr` = 0, `at_left_edge` = 1, `at_right_edge` = 0.
- **Latency and address.** Offset 0; drive row 17, col 42 for 1 cycle.
  - `map_addr` = `{6'd2, 8'd5}` = 0x0205 one cycle later.
  - Two cycles later: `pixel_row_out` = 17, `world_col_out` = 42, `out_of_map` = 0.
- **Right saturation.** Starting from offset 1400, `scroll_step` = 15, `scroll_dir` = 0:
  - first tick → 1408, `at_right_edge` = 1;
  - second tick → still 1408.
  - With offset 1408, col 639 → `world_col_out` = 2047, `out_of_map` = 0, `map_addr[7:0]` = 255.
- **Left saturation.** Offset 3, step 5, `scroll_dir` = 1, one tick → offset 0, `at_left_edge` = 1. A further left tick → still 0.
- **Out-of-map boundaries.**
  - col 640, row 10 → `out_of_map` = 1, `map_addr` = 0.
  - row 480, col 0 → `out_of_map` = 1.
  - col 639, row 479 → `out_of_map` = 0.
- **Tick interactions.**
  - `frame_tick` with `scroll_en` = 0 → offset unchanged.
  - `frame_tick` coincident with `reset` from offset 700 → offset 0.
  - `scroll_step` = 0 tick → offset unchanged.
